// File: rtl/apb_chk_pkg.sv
// Shared types and helpers for the APB shadow checker.
// FSM states, one-hot error codes, saturating add.
package apb_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    ERR_PROTO   = 4'b0001,
    ERR_DATA    = 4'b0010,
    ERR_TIMEOUT = 4'b0100,
    ERR_RANGE   = 4'b1000
  } err_t;

  localparam int ERR_N = 4;
  localparam int SAT_W = 32;

  // a + b clamped to the all-ones value of a w-bit counter (w <= SAT_W)
  function automatic logic [SAT_W-1:0] sat_add(
    input logic [SAT_W-1:0] a,
    input logic [SAT_W-1:0] b,
    input int               w
  );
    logic [SAT_W:0] s;
    logic [SAT_W:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = ((SAT_W+1)'(1) << w) - (SAT_W+1)'(1);
    return (s > m) ? m[SAT_W-1:0] : s[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/apb_shadow_bank.sv
// Shadow register bank: DEPTH x WIDTH, async reset to 0.
// Ports: clk, rst (active low), i_we/i_waddr/i_wdata write, i_raddr/o_rdata comb read.
module apb_shadow_bank #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb_shadow_checker.sv
// Passive APB monitor: protocol/timeout checks plus shadowed read-data compare.
// Ports: APB bus taps in, clr_cnt in; error pulses, sticky flag, counters, last error addr out.
module apb_shadow_checker
  import apb_chk_pkg::*;
#(
  parameter int AMBA_ADDR_WIDTH = 16,
  parameter int AMBA_WORD       = 32,
  parameter int REG_DEPTH       = 16,
  parameter int RO_BASE         = 12,
  parameter int TIMEOUT_CYC     = 16,
  parameter int CNT_W           = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [AMBA_ADDR_WIDTH-1:0] paddr,
  input  logic [AMBA_WORD-1:0]       pwdata,
  input  logic [AMBA_WORD-1:0]       prdata,
  input  logic                       pready,
  input  logic                       clr_cnt,
  output logic                       err_proto,
  output logic                       err_data,
  output logic                       err_timeout,
  output logic                       err_range,
  output logic                       err_any,
  output logic [CNT_W-1:0]           txn_cnt,
  output logic [CNT_W-1:0]           err_cnt,
  output logic [AMBA_ADDR_WIDTH-1:0] last_err_addr
);

  localparam int IDX_FULL = AMBA_ADDR_WIDTH - 2;
  localparam int IDX_W    = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam int WAIT_W   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [IDX_FULL-1:0] DEPTH_L = IDX_FULL'(REG_DEPTH);
  localparam logic [IDX_FULL-1:0] RO_L    = IDX_FULL'(RO_BASE);
  localparam logic [WAIT_W-1:0]   TO_L    = WAIT_W'(TIMEOUT_CYC);

  state_t                     r_state;
  logic [AMBA_ADDR_WIDTH-1:0] r_addr;
  logic                       r_write;
  logic [AMBA_WORD-1:0]       r_wdata;
  logic [WAIT_W-1:0]          r_wait;
  logic [ERR_N-1:0]           r_err;
  logic                       r_any;
  logic [CNT_W-1:0]           r_txn;
  logic [CNT_W-1:0]           r_errc;
  logic [AMBA_ADDR_WIDTH-1:0] r_last;

  logic                       w_ok;
  logic                       w_setup;
  logic [WAIT_W-1:0]          w_wait_inc;
  logic [IDX_FULL-1:0]        w_idx;
  logic                       w_in_range;
  logic                       w_rw;
  logic [AMBA_WORD-1:0]       w_rd;
  logic                       w_we;
  logic                       w_proto;
  logic                       w_complete;
  logic                       w_timeout;
  logic                       w_data;
  logic                       w_range;
  logic [ERR_N-1:0]           w_err;
  logic [SAT_W-1:0]           w_nerr;

  // bus must hold the latched transfer while in the access phase
  assign w_ok = psel && penable &&
                (paddr == r_addr) &&
                (pwrite == r_write) &&
                (pwdata == r_wdata);

  assign w_setup    = psel && !penable;
  assign w_idx      = r_addr[AMBA_ADDR_WIDTH-1:2];
  assign w_in_range = (w_idx < DEPTH_L);
  assign w_rw       = (w_idx < RO_L);

  // first access cycle is seen while still in SETUP, so it counts as wait 1
  assign w_wait_inc = (r_state == ACCESS)
                    ? r_wait + WAIT_W'(1)
                    : WAIT_W'(1);

  always_comb begin
    w_proto    = 1'b0;
    w_complete = 1'b0;
    w_timeout  = 1'b0;
    unique case (r_state)
      IDLE: w_proto = psel && penable;
      SETUP, ACCESS: begin
        if (!w_ok) begin
          w_proto = 1'b1;
        end else if (pready) begin
          w_complete = 1'b1;
        end else if (w_wait_inc == TO_L) begin
          w_timeout = 1'b1;
        end
      end
      default: w_proto = 1'b0;
    endcase
  end

  assign w_range = w_complete && !w_in_range;
  assign w_data  = w_complete && !r_write &&
                   w_in_range && w_rw &&
                   (prdata != w_rd);
  assign w_we    = w_complete && r_write &&
                   w_in_range && w_rw;

  always_comb begin
    w_err = '0;
    if (w_proto)   w_err = w_err | ERR_PROTO;
    if (w_data)    w_err = w_err | ERR_DATA;
    if (w_timeout) w_err = w_err | ERR_TIMEOUT;
    if (w_range)   w_err = w_err | ERR_RANGE;
  end

  assign w_nerr = SAT_W'($countones(w_err));

  apb_shadow_bank #(
    .DEPTH (REG_DEPTH),
    .WIDTH (AMBA_WORD),
    .IDX_W (IDX_W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (r_addr[2 +: IDX_W]),
    .i_wdata (r_wdata),
    .i_raddr (r_addr[2 +: IDX_W]),
    .o_rdata (w_rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_wait  <= '0;
      r_err   <= '0;
      r_any   <= 1'b0;
      r_txn   <= '0;
      r_errc  <= '0;
      r_last  <= '0;
    end else begin
      r_err <= w_err;

      unique case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_state <= SETUP;
            r_addr  <= paddr;
            r_write <= pwrite;
            r_wdata <= pwdata;
          end
        end
        SETUP: begin
          if (!w_ok) begin
            if (w_setup) begin
              r_addr  <= paddr;
              r_write <= pwrite;
              r_wdata <= pwdata;
            end else begin
              r_state <= IDLE;
            end
          end else if (pready || w_timeout) begin
            r_state <= IDLE;
          end else begin
            r_state <= ACCESS;
            r_wait  <= w_wait_inc;
          end
        end
        ACCESS: begin
          if (!w_ok || pready || w_timeout) begin
            r_state <= IDLE;
          end else begin
            r_wait <= w_wait_inc;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (clr_cnt) begin
        r_txn  <= '0;
        r_errc <= '0;
        r_any  <= 1'b0;
      end else begin
        r_txn  <= CNT_W'(sat_add(SAT_W'(r_txn),
                                 SAT_W'(w_complete), CNT_W));
        r_errc <= CNT_W'(sat_add(SAT_W'(r_errc),
                                 w_nerr, CNT_W));
        if (|w_err) r_any <= 1'b1;
      end

      if (|w_err) r_last <= paddr;
    end
  end

  assign err_proto     = |(r_err & ERR_PROTO);
  assign err_data      = |(r_err & ERR_DATA);
  assign err_timeout   = |(r_err & ERR_TIMEOUT);
  assign err_range     = |(r_err & ERR_RANGE);
  assign err_any       = r_any;
  assign txn_cnt       = r_txn;
  assign err_cnt       = r_errc;
  assign last_err_addr = r_last;

endmodule

// File: tb/tb_apb_shadow_checker.sv
// Directed bench for apb_shadow_checker with a pulse scoreboard.
// Expected error pulses are queued at drive time and popped after completion.
module tb_apb_shadow_checker;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          clr_cnt;
  logic          err_proto;
  logic          err_data;
  logic          err_timeout;
  logic          err_range;
  logic          err_any;
  logic [CW-1:0] txn_cnt;
  logic [CW-1:0] err_cnt;
  logic [AW-1:0] last_err_addr;

  always #5 clk = ~clk;

  apb_shadow_checker #(
    .AMBA_ADDR_WIDTH (AW),
    .AMBA_WORD       (DW),
    .REG_DEPTH       (16),
    .RO_BASE         (12),
    .TIMEOUT_CYC     (TO),
    .CNT_W           (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .psel          (psel),
    .penable       (penable),
    .pwrite        (pwrite),
    .paddr         (paddr),
    .pwdata        (pwdata),
    .prdata        (prdata),
    .pready        (pready),
    .clr_cnt       (clr_cnt),
    .err_proto     (err_proto),
    .err_data      (err_data),
    .err_timeout   (err_timeout),
    .err_range     (err_range),
    .err_any       (err_any),
    .txn_cnt       (txn_cnt),
    .err_cnt       (err_cnt),
    .last_err_addr (last_err_addr)
  );

  int            checks = 0;
  int            failures = 0;
  logic [3:0]    exp_q[$];
  logic [DW-1:0] sh [16];
  int            exp_txn;
  int            exp_err;
  logic          exp_any;
  logic [AW-1:0] exp_last;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset;
    for (int i = 0; i < 16; i++) sh[i] = '0;
    exp_txn  = 0;
    exp_err  = 0;
    exp_any  = 1'b0;
    exp_last = '0;
  endtask

  // push the expected pulse vector {range,timeout,data,proto}
  task automatic note_err(input logic [3:0] v,
                          input logic [AW-1:0] a,
                          input logic clr);
    exp_q.push_back(v);
    if (v != 4'b0) begin
      exp_last = a;
      exp_err  = exp_err + $countones(v);
      exp_any  = 1'b1;
    end
    if (clr) begin
      exp_txn = 0;
      exp_err = 0;
      exp_any = 1'b0;
    end
  endtask

  task automatic check_out(input string tag);
    logic [3:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
    chk({tag, "_pulse"},
        {60'b0, err_range, err_timeout, err_data, err_proto}, e);
    chk({tag, "_txn"}, txn_cnt, exp_txn);
    chk({tag, "_errcnt"}, err_cnt, exp_err);
    chk({tag, "_any"}, err_any, exp_any);
    chk({tag, "_last"}, last_err_addr, exp_last);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pulse"},
        {60'b0, err_range, err_timeout, err_data, err_proto}, 0);
    chk({tag, "_txn"}, txn_cnt, 0);
    chk({tag, "_errcnt"}, err_cnt, 0);
    chk({tag, "_any"}, err_any, 0);
    chk({tag, "_last"}, last_err_addr, 0);
  endtask

  task automatic xfer(input string tag,
                      input logic wr,
                      input logic [AW-1:0] a,
                      input logic [DW-1:0] wd,
                      input logic [DW-1:0] rd,
                      input int nw);
    logic [3:0] v;
    int idx;
    v   = 4'b0;
    idx = int'(a >> 2);
    if (nw >= TO) begin
      v = 4'b0100;
    end else begin
      exp_txn++;
      if (idx >= 16) begin
        v = 4'b1000;
      end else if (idx < 12) begin
        if (wr) sh[idx] = wd;
        else if (rd !== sh[idx]) v = 4'b0010;
      end
    end
    note_err(v, a, 1'b0);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    prdata  = '0;
    pready  = 1'b1;
    tick;
    penable = 1'b1;
    prdata  = rd;
    for (int i = 0; i < nw && i < TO; i++) begin
      pready = 1'b0;
      tick;
    end
    if (nw < TO) begin
      pready = 1'b1;
      tick;
    end
    psel    = 1'b0;
    penable = 1'b0;
    pready  = 1'b1;
    check_out(tag);
  endtask

  initial begin
    rst     = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    prdata  = '0;
    pready  = 1'b1;
    clr_cnt = 1'b0;
    model_reset();
    tick;
    tick;
    check_zero("reset");
    rst = 1'b1;
    tick;

    xfer("wr_a5", 1'b1, 16'h0004, 32'hA5A5_0001, '0, 0);
    xfer("rd_a5", 1'b0, 16'h0004, '0, 32'hA5A5_0001, 0);
    xfer("rd_bad", 1'b0, 16'h0004, '0, 32'hA5A5_0000, 0);
    tick;
    chk("data_pulse_end",
        {60'b0, err_range, err_timeout, err_data, err_proto}, 0);

    note_err(4'b0001, 16'h0008, 1'b0);
    psel    = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b0;
    paddr   = 16'h0008;
    tick;
    psel    = 1'b0;
    penable = 1'b0;
    check_out("proto_nosetup");

    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 16'h0004;
    tick;
    penable = 1'b1;
    pready  = 1'b0;
    tick;
    paddr = 16'h0008;
    note_err(4'b0001, 16'h0008, 1'b0);
    tick;
    psel    = 1'b0;
    penable = 1'b0;
    pready  = 1'b1;
    check_out("proto_addr");
    xfer("after_proto", 1'b0, 16'h0004, '0, 32'hA5A5_0001, 0);

    xfer("timeout", 1'b1, 16'h0008, 32'h1234_5678, '0, 16);
    xfer("rd_after_to", 1'b0, 16'h0008, '0, 32'h0, 0);
    xfer("wait15", 1'b1, 16'h0008, 32'hDEAD_BEEF, '0, 15);
    xfer("rd_w15", 1'b0, 16'h0008, '0, 32'hDEAD_BEEF, 0);

    xfer("ro_wr", 1'b1, 16'h0030, 32'h0000_FFFF, '0, 0);
    xfer("ro_rd", 1'b0, 16'h0030, '0, 32'h0, 0);
    xfer("range", 1'b0, 16'h0050, '0, 32'h0, 0);

    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 16'h0004;
    pwdata  = 32'h0000_0001;
    tick;
    penable = 1'b1;
    pready  = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    #1;
    check_zero("rst_mid");
    psel    = 1'b0;
    penable = 1'b0;
    pready  = 1'b1;
    #2;
    rst = 1'b1;
    model_reset();
    tick;
    xfer("post_rst_rd", 1'b0, 16'h0004, '0, 32'h0, 0);

    note_err(4'b0001, 16'h000C, 1'b1);
    psel    = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b0;
    paddr   = 16'h000C;
    clr_cnt = 1'b1;
    tick;
    clr_cnt = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    check_out("clr_coinc");
    xfer("after_clr", 1'b0, 16'h0050, '0, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
